// File: rtl/rf_write_arb_pkg.sv
// Shared register-file constants and the write-arbiter FSM state type.
package wi23_defs;

    localparam int unsigned REGFILE_WIDTH = 16;
    localparam int unsigned REGFILE_DEPTH = 5;
    localparam int unsigned ENTRIES       = 1 << REGFILE_DEPTH;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_arb_state_t;

endpackage

// File: rtl/rf_write_arb.sv
// Register-file write-port arbiter: clears the file after reset, then merges
// pipeline writeback with long-latency results through a one-entry buffer.
module rf_write_arb
    import wi23_defs::*;
#(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [REGFILE_DEPTH-1:0] wb_regsel,
    input  logic [REGFILE_WIDTH-1:0] wb_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [REGFILE_DEPTH-1:0] lu_regsel,
    input  logic [REGFILE_WIDTH-1:0] lu_data,
    output logic                     rf_write,
    output logic [REGFILE_DEPTH-1:0] rf_writeregsel,
    output logic [REGFILE_WIDTH-1:0] rf_writedata,
    output logic                     init_done,
    output logic                     pipe_stall,
    output logic                     lu_kill,
    output logic                     err
);

    localparam rf_arb_state_t RESET_STATE = INIT_ON_RESET ? CLEAR : RUN;

    rf_arb_state_t              state_q, state_d;
    logic [REGFILE_DEPTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [REGFILE_DEPTH-1:0]   buf_regsel_q, buf_regsel_d;
    logic [REGFILE_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                       rf_write_q, rf_write_d;
    logic [REGFILE_DEPTH-1:0]   rf_writeregsel_q, rf_writeregsel_d;
    logic [REGFILE_WIDTH-1:0]   rf_writedata_q, rf_writedata_d;
    logic                       lu_kill_q, lu_kill_d;
    logic                       err_q, err_d;
    logic                       lu_ready_run;
    logic                       lu_accept;
    logic                       buf_kill;

    always_comb begin
        state_d          = state_q;
        clr_cnt_d        = clr_cnt_q;
        buf_valid_d      = buf_valid_q;
        buf_regsel_d     = buf_regsel_q;
        buf_data_d       = buf_data_q;
        rf_write_d       = 1'b0;
        rf_writeregsel_d = rf_writeregsel_q;
        rf_writedata_d   = rf_writedata_q;
        lu_kill_d        = 1'b0;
        err_d            = 1'b0;
        lu_ready_run     = 1'b0;
        lu_accept        = 1'b0;
        buf_kill         = 1'b0;

        case (state_q)
            CLEAR: begin
                rf_write_d       = 1'b1;
                rf_writeregsel_d = clr_cnt_q;
                rf_writedata_d   = '0;
                err_d            = wb_valid | lu_valid;
                clr_cnt_d        = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                lu_ready_run = !buf_valid_q || !wb_valid;
                lu_accept    = lu_valid && lu_ready_run;
                // A younger WB write to the buffered register makes the LU entry stale.
                buf_kill     = wb_valid && buf_valid_q && (wb_regsel == buf_regsel_q);
                lu_kill_d    = buf_kill;
                if (wb_valid) begin
                    rf_write_d       = 1'b1;
                    rf_writeregsel_d = wb_regsel;
                    rf_writedata_d   = wb_data;
                    if (buf_kill) begin
                        buf_valid_d = 1'b0;
                    end
                end else if (buf_valid_q) begin
                    rf_write_d       = 1'b1;
                    rf_writeregsel_d = buf_regsel_q;
                    rf_writedata_d   = buf_data_q;
                    buf_valid_d      = 1'b0;
                end
                if (lu_accept) begin
                    buf_valid_d  = 1'b1;
                    buf_regsel_d = lu_regsel;
                    buf_data_d   = lu_data;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RESET_STATE;
            clr_cnt_q        <= '0;
            buf_valid_q      <= 1'b0;
            buf_regsel_q     <= '0;
            buf_data_q       <= '0;
            rf_write_q       <= 1'b0;
            rf_writeregsel_q <= '0;
            rf_writedata_q   <= '0;
            lu_kill_q        <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            clr_cnt_q        <= clr_cnt_d;
            buf_valid_q      <= buf_valid_d;
            buf_regsel_q     <= buf_regsel_d;
            buf_data_q       <= buf_data_d;
            rf_write_q       <= rf_write_d;
            rf_writeregsel_q <= rf_writeregsel_d;
            rf_writedata_q   <= rf_writedata_d;
            lu_kill_q        <= lu_kill_d;
            err_q            <= err_d;
        end
    end

    // Gated by rst_n so the LU side sees no acceptance while held in reset.
    assign lu_ready       = rst_n && lu_ready_run;
    assign init_done      = rst_n && (state_q == RUN);
    assign pipe_stall     = (state_q == CLEAR);
    assign rf_write       = rf_write_q;
    assign rf_writeregsel = rf_writeregsel_q;
    assign rf_writedata   = rf_writedata_q;
    assign lu_kill        = lu_kill_q;
    assign err            = err_q;

endmodule

// File: tb/tb_rf_write_arb.sv
// Scoreboard bench: the driver predicts each cycle's registered outputs from a
// queue-level model; the monitor pops and compares one prediction per cycle.
module tb_rf_write_arb;
    import wi23_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_regsel;
    logic [15:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_regsel;
    logic [15:0] lu_data;
    logic        rf_write;
    logic [4:0]  rf_writeregsel;
    logic [15:0] rf_writedata;
    logic        init_done;
    logic        pipe_stall;
    logic        lu_kill;
    logic        err;

    always #5 clk = ~clk;

    rf_write_arb #(.INIT_ON_RESET(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_regsel      (wb_regsel),
        .wb_data        (wb_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_regsel      (lu_regsel),
        .lu_data        (lu_data),
        .rf_write       (rf_write),
        .rf_writeregsel (rf_writeregsel),
        .rf_writedata   (rf_writedata),
        .init_done      (init_done),
        .pipe_stall     (pipe_stall),
        .lu_kill        (lu_kill),
        .err            (err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [15:0] data;
        logic        kill;
        logic        err;
        logic        run;
    } exp_t;

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] data;
    } lu_t;

    exp_t        sb_q[$];
    lu_t         pend_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          clr_left;
    logic [4:0]  last_sel;
    logic [15:0] last_data;
    exp_t        mon_e;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; predicts the outputs after the next rising edge.
    task automatic step(input logic wbv, input logic [4:0] wbs, input logic [15:0] wbd,
                        input logic luv, input logic [4:0] lus, input logic [15:0] lud);
        exp_t e;
        lu_t  n;
        logic ready;
        wb_valid  = wbv;
        wb_regsel = wbs;
        wb_data   = wbd;
        lu_valid  = luv;
        lu_regsel = lus;
        lu_data   = lud;
        #1;
        e.we = 1'b0; e.sel = '0; e.data = '0; e.kill = 1'b0; e.err = 1'b0; e.run = 1'b1;
        if (clr_left > 0) begin
            chk("clr_lu_ready", lu_ready, 0);
            chk("clr_pipe_stall", pipe_stall, 1);
            chk("clr_init_done", init_done, 0);
            e.we   = 1'b1;
            e.sel  = 5'(int'(ENTRIES) - clr_left);
            e.data = '0;
            e.err  = wbv | luv;
            clr_left--;
            e.run  = (clr_left == 0);
        end else begin
            ready = (pend_q.size() == 0) || !wbv;
            chk("lu_ready", lu_ready, ready);
            chk("run_pipe_stall", pipe_stall, 0);
            chk("run_init_done", init_done, 1);
            if (wbv) begin
                e.we = 1'b1; e.sel = wbs; e.data = wbd;
                if (pend_q.size() > 0 && pend_q[0].sel == wbs) begin
                    pend_q.delete();
                    e.kill = 1'b1;
                end
            end else if (pend_q.size() > 0) begin
                n = pend_q.pop_front();
                e.we = 1'b1; e.sel = n.sel; e.data = n.data;
            end
            if (luv && ready) begin
                n.sel = lus; n.data = lud;
                pend_q.push_back(n);
            end
        end
        if (e.we) begin
            last_sel = e.sel; last_data = e.data;
        end else begin
            e.sel = last_sel; e.data = last_data;
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rf_write"}, rf_write, 0);
        chk({tag, "_rf_sel"}, rf_writeregsel, 0);
        chk({tag, "_rf_data"}, rf_writedata, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_pipe_stall"}, pipe_stall, 1);
        chk({tag, "_lu_ready"}, lu_ready, 0);
        chk({tag, "_lu_kill"}, lu_kill, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Entered at a falling edge; leaves rst_n released at a later falling edge.
    task automatic do_reset(input logic luv_during);
        wb_valid = 1'b0; lu_valid = luv_during; lu_regsel = 5'd1; lu_data = 16'h1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        pend_q.delete();
        clr_left  = int'(ENTRIES);
        last_sel  = '0;
        last_data = '0;
        check_reset_vals("rst_async");
        @(posedge clk); #1;
        check_reset_vals("rst_hold");
        @(negedge clk);
        lu_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("rf_write", rf_write, mon_e.we);
            chk("rf_writeregsel", rf_writeregsel, mon_e.sel);
            chk("rf_writedata", rf_writedata, mon_e.data);
            chk("lu_kill", lu_kill, mon_e.kill);
            chk("err", err, mon_e.err);
            chk("init_done", init_done, mon_e.run);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_regsel = '0; wb_data = '0;
        lu_valid = 1'b0; lu_regsel = '0; lu_data = '0;
        clr_left = int'(ENTRIES); last_sel = '0; last_data = '0;
        @(negedge clk);
        do_reset(1'b0);

        // Clear sequence with a stray writeback in the middle.
        for (int unsigned i = 0; i < ENTRIES; i++)
            step(i == 10, 5'd3, 16'hFFFF, 1'b0, '0, '0);
        idle(2);

        // Single LU result, no competing writeback.
        step(1'b0, '0, '0, 1'b1, 5'd5, 16'h00A5);
        idle(3);

        // Buffered LU entry waits behind three writebacks.
        step(1'b0, '0, '0, 1'b1, 5'd7, 16'h0011);
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, 5'd3, 16'h0100 + 16'(i), 1'b1, 5'd8, 16'h0055);
        idle(2);

        // Younger writeback to the buffered register kills it.
        step(1'b0, '0, '0, 1'b1, 5'd9, 16'h0022);
        step(1'b1, 5'd9, 16'h0033, 1'b0, '0, '0);
        idle(2);

        // Same-cycle accept and writeback to one register: LU is buffered.
        step(1'b1, 5'd4, 16'h0044, 1'b1, 5'd4, 16'h0045);
        idle(2);

        for (int unsigned i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom));
        idle(2);

        // Reset in RUN with a buffered entry: discarded silently.
        step(1'b0, '0, '0, 1'b1, 5'd6, 16'h0066);
        do_reset(1'b1);

        // Reset at clr_cnt=12, then a full clear.
        for (int unsigned i = 0; i < 12; i++) idle(1);
        do_reset(1'b0);
        for (int unsigned i = 0; i < ENTRIES; i++) idle(1);
        step(1'b0, '0, '0, 1'b1, 5'd2, 16'hBEEF);
        idle(3);

        @(posedge clk); #2;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arb.md
RF_WRITE_ARB -- requirements
Module: rf_write_arb

Interface
REQ-001 Parameter: INIT_ON_RESET, 1, when 1 all register-file entries are cleared after reset; when 0 the block enters RUN directly.
REQ-002 Constants REGFILE_WIDTH and REGFILE_DEPTH SHALL come from wi23_defs; ENTRIES = 1 << REGFILE_DEPTH.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wb_valid  in  1  pipeline writeback request; never back-pressured.
REQ-006 wb_regsel  in  5  writeback destination register.
REQ-007 wb_data  in  REGFILE_WIDTH  writeback data.
REQ-008 lu_valid  in  1  long-latency unit result valid.
REQ-009 lu_ready  out  1  block accepts the LU result this cycle.
REQ-010 lu_regsel  in  5  LU destination register.
REQ-011 lu_data  in  REGFILE_WIDTH  LU data.
REQ-012 rf_write  out  1  register-file write enable.
REQ-013 rf_writeregsel  out  5  register-file write address.
REQ-014 rf_writedata  out  REGFILE_WIDTH  register-file write data.
REQ-015 init_done  out  1  high once clearing is complete.
REQ-016 pipe_stall  out  1  holds the pipeline while clearing.
REQ-017 lu_kill  out  1  one-cycle pulse when a buffered LU write is discarded.
REQ-018 err  out  1  one-cycle pulse on a protocol violation.

Function
REQ-019 The FSM SHALL have two states, CLEAR and RUN; reset enters CLEAR if INIT_ON_RESET=1, else RUN.
REQ-020 In CLEAR the block SHALL write zero to address clr_cnt each cycle, clr_cnt counting 0 to ENTRIES-1, then enter RUN on the cycle after address ENTRIES-1 is issued.
REQ-021 In CLEAR: pipe_stall=1, init_done=0, lu_ready=0.
REQ-022 In RUN: pipe_stall=0, init_done=1.
REQ-023 In CLEAR, wb_valid=1 or lu_valid=1 SHALL pulse err the next cycle; the request is ignored.
REQ-024 All rf_* outputs SHALL be registered; a write selected in cycle N drives the rf_* outputs during cycle N+1.
REQ-025 The block SHALL contain a one-entry LU buffer (buf_valid, buf_regsel, buf_data).
REQ-026 In RUN, lu_ready = !buf_valid || !wb_valid; an LU transfer occurs when lu_valid && lu_ready.
REQ-027 Write-port priority per cycle: wb_valid first, then buf_valid; an accepted LU result enters the buffer and is never written in its acceptance cycle.
REQ-028 If the buffer drains and a new LU result is accepted in the same cycle, the buffer SHALL hold the new entry.
REQ-029 If wb_valid=1 with wb_regsel equal to buf_regsel while buf_valid=1, the buffered entry SHALL be discarded (buf_valid cleared) and lu_kill SHALL pulse the next cycle, because the WB result is younger.
REQ-030 An LU result accepted in the same cycle as a WB write to the same register SHALL be buffered, not killed.
REQ-031 If no source is selected, rf_write SHALL be 0 the next cycle, with rf_writeregsel and rf_writedata holding their previous values.
REQ-032 Maximum write-port throughput SHALL be one write per cycle; LU latency from acceptance to rf_write SHALL be at least 2 cycles.

Reset
REQ-033 Asserting rst_n low SHALL immediately clear: rf_write=0, rf_writeregsel=0, rf_writedata=0, buf_valid=0, clr_cnt=0, lu_kill=0, err=0, init_done=0; pipe_stall=INIT_ON_RESET.
REQ-034 Reset asserted mid-CLEAR or mid-RUN SHALL restart from REQ-019, discarding any buffered LU entry without a lu_kill pulse.
REQ-035 lu_ready SHALL be 0 while rst_n=0.

Structure
REQ-036 The FSM state enum SHALL be added to wi23_defs as rf_arb_state_t; REGFILE_WIDTH and REGFILE_DEPTH remain there.
REQ-037 The FSM, clear counter, buffer and output registers SHALL all reside in one module; no sub-module is required.

Verification
REQ-038 Reset release, INIT_ON_RESET=1 -> 32 writes of 0 to addresses 0..31 on consecutive cycles; init_done=1 and pipe_stall=0 on the cycle after address 31.
REQ-039 RUN, lu_valid with reg 5 = 0xA5 and no WB -> lu_ready=1; rf_write to reg 5 with data 0xA5 exactly 2 cycles after acceptance.
REQ-040 Buffer holds reg 7 = 0x11 while WB writes reg 3 for 3 consecutive cycles -> three reg-3 writes, then the reg-7 write; lu_ready=0 during those 3 cycles.
REQ-041 Buffer holds reg 9 = 0x22 and a WB write to reg 9 = 0x33 arrives -> reg 9 is written with 0x33 only; lu_kill pulses once.
REQ-042 wb_valid asserted during CLEAR -> err pulses once; the clear sequence continues unchanged.
REQ-043 rst_n asserted low at clr_cnt=12 and released -> clearing restarts at address 0 and all outputs show reset values while rst_n=0.
